uart_rx_core_param: RTL

Parametrised UART receive core: the successor to the fixed 8-bit Rx control FSM. Integrates the edge/bit counters, 3-sample majority voter, deserializer, parity and stop checking in one block. Supports configurable data width, 1 or 2 stop bits, even/odd parity, and explicit error reporting. Sits between the Rx input synchronizer and the Rx data consumer, e.g. the register file or the async FIFO.

---
 rtl/uart_rx_core_param.sv | 223 ++++++++++++++++++++++
 1 files changed

// File: rtl/uart_rx_core_param.sv
`default_nettype none
// ============================================================================
// Module  : uart_rx_core_param
// Brief   : Parametrised UART receiver with 3-sample majority voting, parity and
//           stop checking. Optional break detection via UART_RX_BREAK_DET_EN.
// Rev     : 1.0
// ============================================================================
module uart_rx_core_param #(
    parameter int DATA_WIDTH = 8,
    parameter int PRESCALE_W = 6,
    parameter int STOP_BITS  = 1
) (
    input  logic                  CLK,
    input  logic                  Reset,
    input  logic                  S_Data,
    input  logic [PRESCALE_W-1:0] Prescale,
    input  logic                  Parity_EN,
    input  logic                  Parity_type,
    output logic [DATA_WIDTH-1:0] P_Data,
    output logic                  Data_valid,
    output logic                  Parity_error,
    output logic                  Frame_error,
    output logic                  Busy
`ifdef UART_RX_BREAK_DET_EN
    ,output logic                 Break
`endif
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
`ifdef UART_RX_BREAK_DET_EN
        ,S_BREAK_WAIT = 3'd5
`endif
    } state_t;

    localparam logic [PRESCALE_W-1:0] c_one       = PRESCALE_W'(1);
    localparam logic [PRESCALE_W-1:0] c_pmin      = PRESCALE_W'(4);
    localparam logic [3:0]            c_data_last = 4'(DATA_WIDTH - 1);
    localparam logic [3:0]            c_stop_last = 4'(STOP_BITS - 1);

    state_t                  state_q, state_d;
    logic [PRESCALE_W-1:0]   edge_q, edge_d, presc_q, presc_d;
    logic [3:0]              bit_q, bit_d;
    logic                    par_en_q, par_en_d, par_type_q, par_type_d;
    logic [DATA_WIDTH-1:0]   shift_q, shift_d, data_q, data_d;
    logic [1:0]              samp_q, samp_d;
    logic                    par_flag_q, par_flag_d, stop_err_q, stop_err_d;
    logic                    dv_q, dv_d, pe_q, pe_d, fe_q, fe_d;
`ifdef UART_RX_BREAK_DET_EN
    logic                    par_bit_q, par_bit_d, brk_q, brk_d;
`endif

    logic [PRESCALE_W-1:0]   w_half, w_presc_eff;
    logic                    w_bit_end, w_at_hm1, w_at_h, w_decide, w_maj, w_in_frame;

    assign w_half      = presc_q >> 1;
    assign w_bit_end   = (edge_q == presc_q - c_one);
    assign w_at_hm1    = (edge_q == w_half - c_one);
    assign w_at_h      = (edge_q == w_half);
    assign w_decide    = (edge_q == w_half + c_one);
    // Third vote is the live line value at edge h+1
    assign w_maj       = (samp_q[0] & samp_q[1]) | (samp_q[0] & S_Data) | (samp_q[1] & S_Data);
    assign w_presc_eff = (Prescale < c_pmin) ? c_pmin : Prescale;
    assign w_in_frame  = (state_q == S_START) || (state_q == S_DATA) ||
                         (state_q == S_PARITY) || (state_q == S_STOP);

    always_comb begin
        state_d    = state_q;
        edge_d     = edge_q;
        bit_d      = bit_q;
        presc_d    = presc_q;
        par_en_d   = par_en_q;
        par_type_d = par_type_q;
        shift_d    = shift_q;
        data_d     = data_q;
        samp_d     = samp_q;
        par_flag_d = par_flag_q;
        stop_err_d = stop_err_q;
        dv_d       = 1'b0;
        pe_d       = 1'b0;
        fe_d       = 1'b0;
`ifdef UART_RX_BREAK_DET_EN
        par_bit_d  = par_bit_q;
        brk_d      = 1'b0;
`endif
        if (w_in_frame) begin
            edge_d = w_bit_end ? '0 : edge_q + c_one;
            if (w_at_hm1) samp_d[0] = S_Data;
            if (w_at_h)   samp_d[1] = S_Data;
        end

        case (state_q)
            S_IDLE: begin
                if (!S_Data) begin
                    state_d    = S_START;
                    edge_d     = c_one;
                    presc_d    = w_presc_eff;
                    par_en_d   = Parity_EN;
                    par_type_d = Parity_type;
                    bit_d      = '0;
                    par_flag_d = 1'b0;
                    stop_err_d = 1'b0;
                end
            end
            S_START: begin
                if (w_decide && w_maj) begin
                    state_d = S_IDLE;
                    edge_d  = '0;
                end else if (w_bit_end) begin
                    state_d = S_DATA;
                end
            end
            S_DATA: begin
                if (w_decide) shift_d = {w_maj, shift_q[DATA_WIDTH-1:1]};
                if (w_bit_end) begin
                    if (bit_q == c_data_last) begin
                        bit_d   = '0;
                        state_d = par_en_q ? S_PARITY : S_STOP;
                    end else begin
                        bit_d = bit_q + 4'd1;
                    end
                end
            end
            S_PARITY: begin
                if (w_decide) begin
                    par_flag_d = (w_maj != ((^shift_q) ^ par_type_q));
`ifdef UART_RX_BREAK_DET_EN
                    par_bit_d  = w_maj;
`endif
                end
                if (w_bit_end) state_d = S_STOP;
            end
            S_STOP: begin
                if (w_decide) begin
`ifdef UART_RX_BREAK_DET_EN
                    if (bit_q == 4'd0 && !w_maj && shift_q == '0 && !(par_en_q && par_bit_q)) begin
                        brk_d   = 1'b1;
                        state_d = S_BREAK_WAIT;
                        edge_d  = '0;
                    end else
`endif
                    if (bit_q == c_stop_last) begin
                        // Leave on the last vote so a back-to-back start edge is not missed
                        state_d = S_IDLE;
                        edge_d  = '0;
                        fe_d    = stop_err_q | ~w_maj;
                        pe_d    = par_flag_q;
                        if (!(stop_err_q | ~w_maj) && !par_flag_q) begin
                            dv_d   = 1'b1;
                            data_d = shift_q;
                        end
                    end else if (!w_maj) begin
                        stop_err_d = 1'b1;
                    end
                end
                if (w_bit_end) bit_d = bit_q + 4'd1;
            end
`ifdef UART_RX_BREAK_DET_EN
            S_BREAK_WAIT: begin
                if (S_Data) state_d = S_IDLE;
            end
`endif
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            state_q    <= S_IDLE;
            edge_q     <= '0;
            bit_q      <= '0;
            presc_q    <= '0;
            par_en_q   <= 1'b0;
            par_type_q <= 1'b0;
            shift_q    <= '0;
            data_q     <= '0;
            samp_q     <= '0;
            par_flag_q <= 1'b0;
            stop_err_q <= 1'b0;
            dv_q       <= 1'b0;
            pe_q       <= 1'b0;
            fe_q       <= 1'b0;
`ifdef UART_RX_BREAK_DET_EN
            par_bit_q  <= 1'b0;
            brk_q      <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            edge_q     <= edge_d;
            bit_q      <= bit_d;
            presc_q    <= presc_d;
            par_en_q   <= par_en_d;
            par_type_q <= par_type_d;
            shift_q    <= shift_d;
            data_q     <= data_d;
            samp_q     <= samp_d;
            par_flag_q <= par_flag_d;
            stop_err_q <= stop_err_d;
            dv_q       <= dv_d;
            pe_q       <= pe_d;
            fe_q       <= fe_d;
`ifdef UART_RX_BREAK_DET_EN
            par_bit_q  <= par_bit_d;
            brk_q      <= brk_d;
`endif
        end
    end

    assign P_Data       = data_q;
    assign Data_valid   = dv_q;
    assign Parity_error = pe_q;
    assign Frame_error  = fe_q;
    assign Busy         = (state_q != S_IDLE);
`ifdef UART_RX_BREAK_DET_EN
    assign Break        = brk_q;
`endif

endmodule
`default_nettype wire
